pim_host_req_frontend: RTL
==========================

// Module: pim_host_req_frontend
// PURPOSE
//  Host-side front end sitting directly upstream of the PIM system top (DDR3 controller + MAC engine).
//  Buffers tagged host read requests, issues them in order on the controller's 32-bit req valid/ready port,
//  and caps the number of requests in flight at the controller.
//  Returns each 512-bit line response to the host with the original tag, using in-order tag tracking.
//  Also keeps sticky error state and performance counters.
// PARAMETERS
//  REQ_DEPTH        8    host request FIFO entries (power of 2, >=2)
//  MAX_OUTSTANDING  4    max requests issued to controller and not yet answered (power of 2, >=1)
//  TAG_W            4    host tag width
//  ALIGN_LINE       1    1: force ctrl_req_addr[5:0]=0 (64-byte line); 0: pass address unchanged
// PORTS
//  clk              in   1    single clock, shared with the controller
//  rst              in   1    asynchronous, active-high reset
//  host_req_valid   in   1    host request valid
//  host_req_ready   out  1    FIFO can accept a request
//  host_req_addr    in   32   byte address
//  host_req_tag     in   TAG_W  host tag, returned with the response
//  host_resp_valid  out  1    response valid
//  host_resp_ready  in   1    host accepts the response
//  host_resp_data   out  512  line data
//  host_resp_tag    out  TAG_W  tag of the matching request
//  ctrl_req_valid   out  1    request to controller
//  ctrl_req_ready   in   1    controller accepts the request
//  ctrl_req_addr    out  32   address to controller
//  ctrl_resp_valid  in   1    controller response valid
//  ctrl_resp_ready  out  1    frontend accepts the controller response
//  ctrl_resp_data   in   512  controller line data
//  q_level          out  $clog2(REQ_DEPTH)+1  request FIFO occupancy
//  outstanding      out  $clog2(MAX_OUTSTANDING)+1  in-flight count
//  err_unexpected   out  1    sticky: controller response arrived with no tracked tag
//  issue_count      out  32   requests issued to controller (wraps at 2^32)
//  stall_count      out  32   cycles with FIFO non-empty but issue blocked (credit limit or !ctrl_req_ready)
// BEHAVIOUR
//  Reset values: every output reg = 0; FIFOs empty; host_req_ready = 1 one cycle after rst deasserts.
//  Request FIFO: push on host_req_valid & host_req_ready.
//   - host_req_ready = (q_level != REQ_DEPTH). No bypass path, so nothing is pushed while full.
//   - Push and pop in the same cycle are legal when not full; q_level stays unchanged.
//  Issue: ctrl_req_valid = FIFO non-empty & (outstanding < MAX_OUTSTANDING).
//   - ctrl_req_addr and the head tag come straight from registered FIFO storage.
//   - ctrl_req_valid and ctrl_req_addr stay stable until handshake. Once asserted, valid is not withdrawn.
//  Latency: a request accepted in cycle N appears on ctrl_req_* at N+1 at the earliest (empty FIFO, credit free).
//  Tag FIFO (depth MAX_OUTSTANDING): push head tag on ctrl_req handshake; pop on ctrl_resp handshake.
//  outstanding: +1 on issue, -1 on ctrl_resp handshake. Both in the same cycle leaves it unchanged.
//   - outstanding can never exceed MAX_OUTSTANDING, so the tag FIFO never overflows.
//  Response register: a single output stage.
//   - ctrl_resp_ready = !host_resp_valid | host_resp_ready, so back-to-back responses flow at full rate.
//   - ctrl_resp handshake in cycle M loads data plus the popped tag; host_resp_valid = 1 at M+1.
//   - host_resp_* stay stable while valid & !ready.
//  Unexpected response (ctrl_resp handshake while the tag FIFO is empty):
//   - response dropped; err_unexpected set to 1 until rst; outstanding stays at 0 (no underflow).
//  Ordering: responses return strictly in issue order; the controller is in-order.
//  stall_count increments in every cycle with FIFO non-empty and no issue handshake.
//  Counters wrap modulo 2^32 silently.
//  Reset mid-operation: all state is cleared immediately and the controller's in-flight requests are abandoned.
//   - Controller responses arriving after reset set err_unexpected. The system must reset both blocks together.
// STRUCTURE
//  pim_pkg: PIM_LINE_BITS=512, PIM_ADDR_W=32, PIM_LINE_OFS_BITS=6, default TAG_W.
//  Sub-module pim_sync_fifo #(WIDTH, DEPTH):
//   - registered storage, count output, full/empty flags.
//   - instantiated twice: request FIFO (32+TAG_W bits wide) and tag FIFO (TAG_W bits wide).
//  Top level adds credit logic, the response register, error flag and counters.
// TESTING
//  1. Single read: addr 0x0000_1234, tag 3; controller answers 5 cycles after issue with data 512'hA5..A5.
//     -> ctrl_req_addr = 0x0000_1200 (ALIGN_LINE=1); host_resp_tag = 3; host_resp_data = all A5.
//  2. Credit cap: push 6 requests with ctrl_req_ready=1 and no responses.
//     -> exactly 4 issued; outstanding = 4; q_level = 2; stall_count increments every cycle.
//     -> after one response, the 5th request issues the next cycle.
//  3. Full FIFO: ctrl_req_ready=0, push 9 requests.
//     -> 8 accepted; host_req_ready = 0 from the 8th push on; q_level = 8; 9th held until a pop.
//  4. Host backpressure: 3 responses back-to-back with host_resp_ready=0 for 4 cycles.
//     -> ctrl_resp_ready deasserts; no data loss; tags 0,1,2 delivered in order.
//  5. Spurious ctrl_resp_valid with nothing outstanding -> err_unexpected = 1; no host response; outstanding stays 0.
//  6. Assert rst with 2 in flight and 3 queued -> every output 0 next edge; later responses set err_unexpected.

Source files
------------

// File: rtl/pim_pkg.sv
// pim_pkg
//  Shared constants for the PIM host-side blocks: line and address geometry,
//  the default host tag width, and a helper that clears the in-line byte
//  offset of an address so requests hit the start of a 64-byte line.
package pim_pkg;

    localparam int PIM_LINE_BITS     = 512;
    localparam int PIM_ADDR_W        = 32;
    localparam int PIM_LINE_OFS_BITS = 6;
    localparam int PIM_DEFAULT_TAG_W = 4;

    // Keeps every address bit above the line offset and clears the offset bits.
    localparam logic [PIM_ADDR_W-1:0] PIM_LINE_MASK =
        ~((32'd1 << PIM_LINE_OFS_BITS) - 32'd1);

    function automatic logic [PIM_ADDR_W-1:0] pim_line_align(input logic [PIM_ADDR_W-1:0] addr);
        return addr & PIM_LINE_MASK;
    endfunction

endpackage

// File: rtl/pim_sync_fifo.sv
// pim_sync_fifo
//  Single-clock FIFO with registered storage. The head entry is read straight
//  out of the storage registers, so dout is valid whenever empty is low.
//  A push while full and a pop while empty are ignored.
// Ports
//  clk, rst   clock and asynchronous active-high reset (clears storage too)
//  push, din  write strobe and data
//  pop        remove the head entry
//  dout       head entry
//  count      occupancy, 0..DEPTH
//  full/empty occupancy flags
module pim_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    // A 1-entry FIFO still needs a 1-bit pointer.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH values that do not fill the
    // pointer range still work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage is reset so the head output reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/pim_host_req_frontend.sv
// pim_host_req_frontend
//  Host-side front end for the PIM system top. Queues tagged host read
//  requests, issues them in order to the controller while limiting the
//  number in flight, and returns each 512-bit line with the tag of the
//  request it answers. Also keeps a sticky error flag and perf counters.
// Ports
//  clk, rst                 shared clock, asynchronous active-high reset
//  host_req_*               tagged host read requests (valid/ready)
//  host_resp_*              line responses with original tag (valid/ready)
//  ctrl_req_*               line address requests to the controller
//  ctrl_resp_*              line data from the in-order controller
//  q_level                  request FIFO occupancy
//  outstanding              requests issued and not yet answered
//  err_unexpected           sticky: a response arrived with nothing in flight
//  issue_count, stall_count wrapping performance counters
module pim_host_req_frontend
    import pim_pkg::*;
#(
    parameter int REQ_DEPTH       = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_W           = PIM_DEFAULT_TAG_W,
    parameter bit ALIGN_LINE      = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               host_req_valid,
    output logic                               host_req_ready,
    input  logic [PIM_ADDR_W-1:0]              host_req_addr,
    input  logic [TAG_W-1:0]                   host_req_tag,
    output logic                               host_resp_valid,
    input  logic                               host_resp_ready,
    output logic [PIM_LINE_BITS-1:0]           host_resp_data,
    output logic [TAG_W-1:0]                   host_resp_tag,
    output logic                               ctrl_req_valid,
    input  logic                               ctrl_req_ready,
    output logic [PIM_ADDR_W-1:0]              ctrl_req_addr,
    input  logic                               ctrl_resp_valid,
    output logic                               ctrl_resp_ready,
    input  logic [PIM_LINE_BITS-1:0]           ctrl_resp_data,
    output logic [$clog2(REQ_DEPTH):0]         q_level,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_unexpected,
    output logic [31:0]                        issue_count,
    output logic [31:0]                        stall_count
);

    localparam int REQ_W = PIM_ADDR_W + TAG_W;

    logic             ready_en;
    logic             req_full;
    logic             req_empty;
    logic             req_push;
    logic             issue_fire;
    logic [REQ_W-1:0] req_dout;
    logic [PIM_ADDR_W-1:0] head_addr;
    logic [TAG_W-1:0] head_tag;
    logic             tag_full;
    logic             tag_empty;
    logic [TAG_W-1:0] tag_dout;
    logic             resp_fire;
    logic             resp_expected;
    logic             resp_unexpected;

    // Holds both ready outputs low while in reset and for the first edge
    // after release, so every output reads zero during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign host_req_ready = ready_en & ~req_full;
    assign req_push       = host_req_valid & host_req_ready;

    pim_sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_push),
        .din   ({host_req_addr, host_req_tag}),
        .pop   (issue_fire),
        .dout  (req_dout),
        .count (q_level),
        .full  (req_full),
        .empty (req_empty)
    );

    assign head_addr = req_dout[TAG_W +: PIM_ADDR_W];
    assign head_tag  = req_dout[TAG_W-1:0];

    // The tag FIFO is exactly MAX_OUTSTANDING deep and holds one tag per
    // request in flight, so "tag FIFO full" is the credit limit and its
    // occupancy is the outstanding count. Valid cannot drop before the
    // handshake: the head only leaves on issue and credits only come back.
    assign ctrl_req_valid = ~req_empty & ~tag_full;
    assign issue_fire     = ctrl_req_valid & ctrl_req_ready;
    assign ctrl_req_addr  = ALIGN_LINE ? pim_line_align(head_addr) : head_addr;

    pim_sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue_fire),
        .din   (head_tag),
        .pop   (resp_expected),
        .dout  (tag_dout),
        .count (outstanding),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // A response is only matched against a tag already in flight at the
    // start of the cycle; anything else is dropped and flagged.
    assign ctrl_resp_ready = ready_en & (~host_resp_valid | host_resp_ready);
    assign resp_fire       = ctrl_resp_valid & ctrl_resp_ready;
    assign resp_expected   = resp_fire & ~tag_empty;
    assign resp_unexpected = resp_fire & tag_empty;

    // Single output stage: reloads in the same cycle the host drains it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_resp_valid <= 1'b0;
            host_resp_data  <= '0;
            host_resp_tag   <= '0;
        end else if (resp_expected) begin
            host_resp_valid <= 1'b1;
            host_resp_data  <= ctrl_resp_data;
            host_resp_tag   <= tag_dout;
        end else if (host_resp_ready) begin
            host_resp_valid <= 1'b0;
        end
    end

    // Sticky error plus free-running counters that wrap at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_unexpected <= 1'b0;
            issue_count    <= '0;
            stall_count    <= '0;
        end else begin
            if (resp_unexpected) begin
                err_unexpected <= 1'b1;
            end
            if (issue_fire) begin
                issue_count <= issue_count + 32'd1;
            end
            if (~req_empty & ~issue_fire) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

endmodule
